// File: rtl/lag_corr_mac_if.sv
// Sample-in / result-out bus of the lag correlator MAC bank.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the sample side, out_valid/out_ready on the result side.
//
// Signals: in_valid/in_ready, a_input/b_input (signed samples),
//          out_valid/out_ready, out_data (signed accumulator), out_lag, out_last,
//          out_sat (only when LAG_CORR_SAT_EN is defined).
// Modports: slave = correlator side, master = source/consumer side.
interface lag_corr_mac_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int LAG_W  = 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a_input;
  logic signed [DATA_W-1:0] b_input;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [LAG_W-1:0]         out_lag;
  logic                     out_last;
`ifdef LAG_CORR_SAT_EN
  logic                     out_sat;
`endif

  modport slave (
    input  in_valid, a_input, b_input, out_ready,
`ifdef LAG_CORR_SAT_EN
    output out_sat,
`endif
    output in_ready, out_valid, out_data, out_lag, out_last
  );

  modport master (
    output in_valid, a_input, b_input, out_ready,
`ifdef LAG_CORR_SAT_EN
    input  out_sat,
`endif
    input  in_ready, out_valid, out_data, out_lag, out_last
  );
endinterface

// File: rtl/lag_corr_mac.sv
// Frame-based cross-correlation acc[k] = sum a[n]*b[n-k] over N_LAGS parallel MAC lanes.
// Latency: first result valid the cycle after the final sample accept, one lag per transfer.
// Backpressure: in_ready only in RUN; results held stable while out_ready is low.
//
// Ports: clk, rst (async active-low), start (frame start, IDLE only), busy (state != IDLE),
//        io (lag_corr_mac_if.slave): sample input and serial result readout.
// Optional build macro LAG_CORR_SAT_EN: saturating accumulate with sticky per-lane out_sat.
module lag_corr_mac #(
  parameter int N_LAGS    = 2,
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 64,
  parameter int FRAME_LEN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  lag_corr_mac_if.slave io
);
  localparam int LAG_W = (N_LAGS > 1) ? $clog2(N_LAGS) : 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, READ} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [LAG_W-1:0]         idx_q;
  logic signed [DATA_W-1:0] tap     [N_LAGS];
  logic signed [ACC_W-1:0]  acc_all [N_LAGS];
`ifdef LAG_CORR_SAT_EN
  logic                     sat_all [N_LAGS];
`endif

  logic clear, accept, frame_done, read_fire, read_last;

  // start clears the whole datapath so a new frame never sees old taps or sums
  assign clear      = (state_q == IDLE) && start;
  assign accept     = (state_q == RUN) && io.in_valid;
  assign frame_done = accept && (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign read_fire  = (state_q == READ) && io.out_ready;
  assign read_last  = (idx_q == LAG_W'(N_LAGS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = (state_q != IDLE);
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_data  = '0;
    io.out_lag   = '0;
    io.out_last  = 1'b0;
`ifdef LAG_CORR_SAT_EN
    io.out_sat   = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        io.in_ready = 1'b1;
        if (frame_done) state_d = READ;
      end
      READ: begin
        io.out_valid = 1'b1;
        io.out_data  = acc_all[idx_q];
        io.out_lag   = idx_q;
        io.out_last  = read_last;
`ifdef LAG_CORR_SAT_EN
        io.out_sat   = sat_all[idx_q];
`endif
        if (read_fire && read_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      if (clear)       cnt_q <= '0;
      else if (accept) cnt_q <= frame_done ? '0 : cnt_q + 1'b1;
      if (frame_done)     idx_q <= '0;
      else if (read_fire) idx_q <= idx_q + 1'b1;
    end
  end

  // Lane 0 multiplies the live b sample; lane k uses b delayed by k accepts.
  assign tap[0] = io.b_input;

  if (N_LAGS > 1) begin : g_dl
    logic signed [DATA_W-1:0] d_q [N_LAGS-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < N_LAGS-1; i++) d_q[i] <= '0;
      end else if (clear) begin
        for (int i = 0; i < N_LAGS-1; i++) d_q[i] <= '0;
      end else if (accept) begin
        d_q[0] <= io.b_input;
        for (int i = 1; i < N_LAGS-1; i++) d_q[i] <= d_q[i-1];
      end
    end

    for (genvar k = 1; k < N_LAGS; k++) begin : g_tap
      assign tap[k] = d_q[k-1];
    end
  end

  for (genvar k = 0; k < N_LAGS; k++) begin : g_lane
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_x;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod    = io.a_input * tap[k];
    assign prod_x  = ACC_W'(prod);
    assign acc_all[k] = acc_q;

`ifdef LAG_CORR_SAT_EN
    logic              sat_q;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic [ACC_W-1:0]  acc_d;

    // One guard bit: overflow iff the two top bits of the widened sum differ.
    assign sum   = {acc_q[ACC_W-1], acc_q} + {prod_x[ACC_W-1], prod_x};
    assign ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_d = !ovf       ? sum[ACC_W-1:0] :
                   sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                {1'b0, {(ACC_W-1){1'b1}}};
    assign sat_all[k] = sat_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else if (clear) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else if (accept) begin
        acc_q <= acc_d;
        sat_q <= sat_q | ovf;
      end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        acc_q <= '0;
      else if (clear)  acc_q <= '0;
      else if (accept) acc_q <= acc_q + prod_x;
    end
`endif
  end
endmodule

// File: tb/tb_lag_corr_mac.sv
// Bench for lag_corr_mac: N_LAGS=2, DATA_W=8, ACC_W=16, FRAME_LEN=4.
// Directed frames plus random frames, each checked against a direct correlation sum model.
// Results are checked with immediate assertions; one summary line at the end.
module tb_lag_corr_mac;
  localparam int N_LAGS = 2;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int FLEN   = 4;
  localparam int LAG_W  = 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;

  lag_corr_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LAG_W(LAG_W)) bus ();

  lag_corr_mac #(.N_LAGS(N_LAGS), .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAME_LEN(FLEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .io   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic signed [DATA_W-1:0] fa [FLEN];
  logic signed [DATA_W-1:0] fb [FLEN];
  longint exp_acc [N_LAGS];
  bit     exp_sat [N_LAGS];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Correlation by definition: b zero-padded before the frame start, accumulation
  // applied sample by sample so wrap/clamp happen in arrival order.
  task automatic compute_model();
    longint lo, hi;
    lo = -(longint'(1) <<< (ACC_W-1));
    hi =  (longint'(1) <<< (ACC_W-1)) - 1;
    for (int k = 0; k < N_LAGS; k++) begin
      longint acc;
      logic signed [ACC_W-1:0] w;
      acc = 0;
      exp_sat[k] = 0;
      for (int n = 0; n < FLEN; n++) begin
        longint bb;
        bb  = (n >= k) ? longint'(fb[n-k]) : 0;
        acc = acc + longint'(fa[n]) * bb;
`ifdef LAG_CORR_SAT_EN
        if (acc > hi) begin acc = hi; exp_sat[k] = 1; end
        if (acc < lo) begin acc = lo; exp_sat[k] = 1; end
`else
        w   = ACC_W'(acc);
        acc = longint'(w);
`endif
      end
      exp_acc[k] = acc;
    end
  endtask

  // mode bits: 0 = idle gaps between samples, 1 = 3-cycle out_ready stall,
  //            2 = start pulses during RUN and READ, 3 = start with in_valid in IDLE
  task automatic run_frame(input string name, input int mode);
    compute_model();
    @(negedge clk);
    start = 1'b1;
    if (mode[3]) begin
      bus.in_valid = 1'b1;
      bus.a_input  = 8'sd100;
      bus.b_input  = 8'sd100;
      chk({name, ":idle_in_ready"}, bus.in_ready, 0);
    end
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk({name, ":busy_run"}, busy, 1);
    for (int n = 0; n < FLEN; n++) begin
      if (mode[0]) begin
        bus.in_valid = 1'b0;
        bus.a_input  = DATA_W'($urandom);
        bus.b_input  = DATA_W'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.a_input  = fa[n];
      bus.b_input  = fb[n];
      start = mode[2] && (n == 1);
      chk({name, ":in_ready"}, bus.in_ready, 1);
      chk({name, ":no_out_in_run"}, bus.out_valid, 0);
      @(negedge clk);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < N_LAGS; k++) begin
      if (mode[1] && k == 0) begin
        for (int s = 0; s < 3; s++) begin
          bus.out_ready = 1'b0;
          chk({name, ":stall_valid"}, bus.out_valid, 1);
          chk({name, ":stall_data"}, bus.out_data, exp_acc[0]);
          chk({name, ":stall_lag"}, bus.out_lag, 0);
          @(negedge clk);
        end
      end
      start = mode[2];
      chk({name, ":out_valid"}, bus.out_valid, 1);
      chk({name, ":out_data"}, bus.out_data, exp_acc[k]);
      chk({name, ":out_lag"}, bus.out_lag, k);
      chk({name, ":out_last"}, bus.out_last, (k == N_LAGS-1) ? 1 : 0);
      chk({name, ":in_ready_read"}, bus.in_ready, 0);
`ifdef LAG_CORR_SAT_EN
      chk({name, ":out_sat"}, bus.out_sat, exp_sat[k]);
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      start = 1'b0;
    end
    chk({name, ":busy_done"}, busy, 0);
    chk({name, ":out_valid_done"}, bus.out_valid, 0);
  endtask

  task automatic set_frame(input int a0, a1, a2, a3, b0, b1, b2, b3);
    fa[0] = DATA_W'(a0); fa[1] = DATA_W'(a1); fa[2] = DATA_W'(a2); fa[3] = DATA_W'(a3);
    fb[0] = DATA_W'(b0); fb[1] = DATA_W'(b1); fb[2] = DATA_W'(b2); fb[3] = DATA_W'(b3);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ":in_ready"}, bus.in_ready, 0);
    chk({tag, ":out_valid"}, bus.out_valid, 0);
    chk({tag, ":out_data"}, bus.out_data, 0);
    chk({tag, ":out_lag"}, bus.out_lag, 0);
    chk({tag, ":out_last"}, bus.out_last, 0);
    chk({tag, ":busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_input   = '0;
    bus.b_input   = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("after_reset");

    set_frame(1, 2, 3, 4, 1, 1, 1, 1);
    run_frame("basic", 0);
    set_frame(-3, -3, -3, -3, 5, 5, 5, 5);
    run_frame("signed", 0);
    set_frame(1, 2, 3, 4, 1, 1, 1, 1);
    run_frame("gaps_stall", 3);
    set_frame(-128, -128, -128, -128, -128, -128, -128, -128);
    run_frame("overflow", 0);

    // abort a frame after two accepts
    set_frame(50, 60, 70, 80, 90, 100, 110, 120);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      bus.in_valid = 1'b1;
      bus.a_input  = fa[n];
      bus.b_input  = fb[n];
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk_quiet("mid_run_reset");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("post_abort");
    set_frame(1, 2, 3, 4, 1, 1, 1, 1);
    run_frame("after_abort", 0);

    run_frame("start_noise", 12);

    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < FLEN; n++) begin
        fa[n] = DATA_W'($urandom);
        fb[n] = DATA_W'($urandom);
      end
      run_frame("random", int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lag_corr_mac.md
Name: lag_corr_mac

Overview:
- Parametrised successor of the two-stage chained MAC: a bank of N_LAGS MAC lanes computing frame-based cross-correlation acc[k] = sum_n a[n]*b[n-k], k = 0..N_LAGS-1.
- Shared b delay line with per-lane accumulators, a frame counter, and a serial result readout with valid/ready handshake.
- Sits between sample sources and downstream result consumers in the MAC datapath.

Parameters:
- N_LAGS, 2, number of lanes/lags (>=1)
- DATA_W, 32, signed width of a_input/b_input
- ACC_W, 64, signed accumulator/result width (must be >= 2*DATA_W)
- FRAME_LEN, 16, accepted samples per frame (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse, honoured only in IDLE
- in_valid  in  1  sample pair valid
- in_ready  out  1  block accepts samples
- a_input  in  DATA_W  signed sample a, broadcast to all lanes
- b_input  in  DATA_W  signed sample b, enters delay line
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  accumulator of lag out_lag
- out_lag  out  max(1,$clog2(N_LAGS))  lag index of out_data
- out_last  out  1  high on final lag of frame
- busy  out  1  high when state != IDLE

Behaviour:
- Reset: rst low asynchronously forces state=IDLE and clears counter, readout index, delay line, and accumulators. All outputs are 0 during and after reset. A reset asserted mid-frame or mid-readout discards the frame with no output.
- FSM states: IDLE, RUN, READ.
- IDLE: in_ready=0, out_valid=0. start=1 moves to RUN next cycle and clears accumulators, delay line (d[0..N_LAGS-2]=0), and counter.
- RUN: in_ready=1. A sample is accepted when in_valid=1.
- On accept: lane k updates acc[k] += a_input * tap_k, where tap_0=b_input and tap_k=d[k-1] for k>=1. The delay line then shifts: d[0]<=b_input, d[k]<=d[k-1]. Cycles with in_valid=0 change nothing.
- Lag k therefore sees b zero-padded for the first k samples of the frame.
- Accept with count==FRAME_LEN-1 moves to READ, with readout index idx=0. The final sample is included in the accumulators.
- READ: in_ready=0. out_valid=1, out_data=acc[idx], out_lag=idx, out_last=(idx==N_LAGS-1).
- Handshake in READ: out_valid&&out_ready advances idx. The transfer with out_last returns to IDLE.
- While out_ready=0, out_data, out_lag, and out_last are held stable.
- Output latency: first result is valid the cycle after the final accept.
- start is ignored in RUN and READ. start and in_valid in the same IDLE cycle: start is taken, the sample is not accepted (in_ready=0).
- Arithmetic: signed product of 2*DATA_W bits, sign-extended to ACC_W, summed modulo 2^ACC_W (wrap) unless the optional feature is enabled.
- Only one frame is in flight at a time; there is no overlap of RUN and READ.

Optional Feature:
- Macro LAG_CORR_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A sticky per-lane overflow bit is set on any clamp and exported on extra port out_sat (1 bit, aligned with out_data). Overflow bits clear on start and reset.
- Undefined: two's-complement wrap; out_sat port absent.

Test Plan:
- Basic, N_LAGS=2, FRAME_LEN=4: start, then accept a=1,2,3,4 with b=1,1,1,1 -> READ emits (lag0, 10), then (lag1, 9) with out_last on lag1; busy drops the cycle after.
- Signed, same config: a=-3, b=5 for all 4 samples -> lag0=-60, lag1=-45.
- Gaps and backpressure: in_valid toggles 1,0,1,0... with the basic data -> same 10/9 results. Hold out_ready=0 for 3 cycles in READ -> out_data=10, out_lag=0 stable; no index advance.
- Saturation, DATA_W=8, ACC_W=16, FRAME_LEN=4, a=b=-128 each sample -> lag0=32767 with out_sat=1 when LAG_CORR_SAT_EN is defined; lag0=0 (wrap of 65536) when undefined.
- Reset mid-RUN after 2 accepts -> all outputs 0, state IDLE. A new frame using the basic data -> exactly 10/9; no residue from the aborted frame.
- start pulsed during RUN and READ -> ignored; results unchanged. start held together with in_valid in IDLE -> that sample is not counted.
